conv_window_sequencer: RTL

Parametrised read sequencer for the NPU convolution layers. It walks a K×K×IN_CH window over an image stored row-interleaved across BANKS image RAMs, and fetches matching weights from the parameter RAM. Each (pixel, weight) pair goes to the MAC array over a valid/ready stream, together with first/last markers and the write-back address of the output pixel. It generalises the fixed four-bank layer-1/2 reader: bank count, image size, kernel size, channel counts, runtime stride 1/2 and downstream backpressure are all supported.

---
 rtl/conv_window_sequencer_if.sv | 37 +++
 rtl/conv_window_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer_if.sv
// Bundle of the convolution sequencer's control, RAM read ports and MAC stream.
// master is the sequencer side; slave is the RAM/MAC/controller side.
interface conv_window_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int BANKS  = 4,
  parameter int IMG_AW = 10,
  parameter int WGT_AW = 15,
  parameter int OUT_AW = 14
);
  logic                    start;
  logic                    cfg_stride2;
  logic                    busy;
  logic                    done;
  logic [IMG_AW-1:0]       img_addr;
  logic [BANKS*DATA_W-1:0] img_rdata;
  logic [WGT_AW-1:0]       wgt_addr;
  logic [DATA_W-1:0]       wgt_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_pix;
  logic [DATA_W-1:0]       out_wgt;
  logic                    out_first;
  logic                    out_last;
  logic [OUT_AW-1:0]       out_wb_addr;

  modport master (
    input  start, cfg_stride2, img_rdata, wgt_rdata, out_ready,
    output busy, done, img_addr, wgt_addr, out_valid, out_pix, out_wgt,
           out_first, out_last, out_wb_addr
  );

  modport slave (
    output start, cfg_stride2, img_rdata, wgt_rdata, out_ready,
    input  busy, done, img_addr, wgt_addr, out_valid, out_pix, out_wgt,
           out_first, out_last, out_wb_addr
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks a KxKxIN_CH window per output pixel over a bank-interleaved image and
// streams (pixel, weight) beats with first/last markers to the MAC array.
module conv_window_sequencer #(
  parameter int DATA_W = 8,
  parameter int BANKS  = 4,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 1,
  parameter int IMG_AW = 10,
  parameter int WGT_AW = 15,
  parameter int OUT_AW = 14
) (
  input logic                    clk,
  input logic                    reset,
  conv_window_sequencer_if.master bus
);
  localparam int CW    = 16;
  localparam int BSH   = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BW    = (BANKS > 1) ? BSH : 1;
  localparam int PLANE = ((IMG_H + BANKS - 1) / BANKS) * IMG_W;
  localparam int OH1   = IMG_H - K + 1;
  localparam int OW1   = IMG_W - K + 1;
  localparam int OH2   = (IMG_H - K) / 2 + 1;
  localparam int OW2   = (IMG_W - K) / 2 + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0] oc_reg, r_reg, c_reg, ic_reg, kr_reg, kc_reg, pix_reg;
  logic [CW-1:0] oc_next, r_next, c_next, ic_next, kr_next, kc_next, pix_next;
  logic [CW-1:0] oh_m1, ow_m1;
  logic          stride_reg, stride_sel;
  logic          load, step, adv, accept, out_valid, busy, done;
  logic          pix_end, final_beat;
  logic [31:0]   row, col;

  logic [IMG_AW-1:0] img_addr_reg, img_addr_next;
  logic [WGT_AW-1:0] wgt_addr_reg, wgt_addr_next;
  logic [BW-1:0]     bank_a_reg, bank_a_next, bank_d_reg;
  logic              first_a_reg, last_a_reg, first_d_reg, last_d_reg, d_valid_reg;
  logic [OUT_AW-1:0] wb_a_reg, wb_d_reg, h_wb_reg;
  logic              h_valid_reg, h_first_reg, h_last_reg;
  logic [DATA_W-1:0] h_pix_reg, h_wgt_reg, live_pix;
  logic [BANKS-1:0][DATA_W-1:0] bank_word;

  assign oh_m1      = stride_reg ? CW'(OH2 - 1) : CW'(OH1 - 1);
  assign ow_m1      = stride_reg ? CW'(OW2 - 1) : CW'(OW1 - 1);
  assign pix_end    = (kc_reg == CW'(K - 1)) && (kr_reg == CW'(K - 1)) && (ic_reg == CW'(IN_CH - 1));
  assign final_beat = pix_end && (c_reg == ow_m1) && (r_reg == oh_m1) && (oc_reg == CW'(OUT_CH - 1));
  assign out_valid  = h_valid_reg | d_valid_reg;
  assign accept     = out_valid & bus.out_ready;
  // A new address may go out only if its data will have somewhere to land next cycle.
  assign adv        = bus.out_ready | ~out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load = 1'b0;
    step = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      IDLE:  if (bus.start) begin state_next = RUN; load = 1'b1; end
      RUN: begin
        busy = 1'b1;
        if (adv) begin
          step = 1'b1;
          if (final_beat) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (accept) state_next = DONE;
      end
      DONE: begin done = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oc_next = oc_reg; r_next = r_reg; c_next = c_reg; ic_next = ic_reg;
    kr_next = kr_reg; kc_next = kc_reg; pix_next = pix_reg;
    if (load || (step && final_beat)) begin
      oc_next = '0; r_next = '0; c_next = '0; ic_next = '0;
      kr_next = '0; kc_next = '0; pix_next = '0;
    end else if (step) begin
      if (kc_reg != CW'(K - 1)) kc_next = kc_reg + 1'b1;
      else begin
        kc_next = '0;
        if (kr_reg != CW'(K - 1)) kr_next = kr_reg + 1'b1;
        else begin
          kr_next = '0;
          if (ic_reg != CW'(IN_CH - 1)) ic_next = ic_reg + 1'b1;
          else begin
            ic_next  = '0;
            pix_next = pix_reg + 1'b1;
            if (c_reg != ow_m1) c_next = c_reg + 1'b1;
            else begin
              c_next = '0;
              if (r_reg != oh_m1) r_next = r_reg + 1'b1;
              else begin r_next = '0; oc_next = oc_reg + 1'b1; end
            end
          end
        end
      end
    end
  end

  // Stride 2 is a left shift of the output coordinate; bank/row split is a mask/shift.
  always_comb begin
    stride_sel    = load ? bus.cfg_stride2 : stride_reg;
    row           = (32'(r_next) << stride_sel) + 32'(kr_next);
    col           = (32'(c_next) << stride_sel) + 32'(kc_next);
    img_addr_next = IMG_AW'(32'(ic_next) * PLANE + (row >> BSH) * IMG_W + col);
    bank_a_next   = BW'(row & 32'(BANKS - 1));
    wgt_addr_next = WGT_AW'(((32'(oc_next) * IN_CH + 32'(ic_next)) * K + 32'(kr_next)) * K + 32'(kc_next));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {oc_reg, r_reg, c_reg, ic_reg, kr_reg, kc_reg, pix_reg} <= '0;
      stride_reg <= 1'b0; img_addr_reg <= '0; wgt_addr_reg <= '0; bank_a_reg <= '0;
      first_a_reg <= 1'b0; last_a_reg <= 1'b0; wb_a_reg <= '0;
    end else if (load || step) begin
      oc_reg <= oc_next; r_reg <= r_next; c_reg <= c_next; ic_reg <= ic_next;
      kr_reg <= kr_next; kc_reg <= kc_next; pix_reg <= pix_next;
      if (load) stride_reg <= bus.cfg_stride2;
      img_addr_reg <= img_addr_next;
      wgt_addr_reg <= wgt_addr_next;
      bank_a_reg   <= bank_a_next;
      first_a_reg  <= (ic_next == '0) && (kr_next == '0) && (kc_next == '0);
      last_a_reg   <= (ic_next == CW'(IN_CH - 1)) && (kr_next == CW'(K - 1)) && (kc_next == CW'(K - 1));
      wb_a_reg     <= OUT_AW'(pix_next);
    end
  end

  // Data stage: metadata follows the address by one cycle to meet the RAM output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid_reg <= 1'b0; bank_d_reg <= '0; first_d_reg <= 1'b0;
      last_d_reg <= 1'b0; wb_d_reg <= '0;
    end else begin
      d_valid_reg <= adv && (state_reg == RUN);
      if (adv) begin
        bank_d_reg <= bank_a_reg; first_d_reg <= first_a_reg;
        last_d_reg <= last_a_reg; wb_d_reg <= wb_a_reg;
      end
    end
  end

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign bank_word[gi] = (32'(bank_d_reg) == gi) ? bus.img_rdata[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    live_pix = '0;
    for (int i = 0; i < BANKS; i++) live_pix = live_pix | bank_word[i];
  end

  // Holding register catches a stalled live beat so the RAMs need not be re-read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_valid_reg <= 1'b0; h_pix_reg <= '0; h_wgt_reg <= '0;
      h_first_reg <= 1'b0; h_last_reg <= 1'b0; h_wb_reg <= '0;
    end else if (h_valid_reg) begin
      if (bus.out_ready) h_valid_reg <= 1'b0;
    end else if (d_valid_reg && !bus.out_ready) begin
      h_valid_reg <= 1'b1; h_pix_reg <= live_pix; h_wgt_reg <= bus.wgt_rdata;
      h_first_reg <= first_d_reg; h_last_reg <= last_d_reg; h_wb_reg <= wb_d_reg;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.img_addr    = img_addr_reg;
  assign bus.wgt_addr    = wgt_addr_reg;
  assign bus.out_valid   = out_valid;
  assign bus.out_pix     = h_valid_reg ? h_pix_reg   : (d_valid_reg ? live_pix      : '0);
  assign bus.out_wgt     = h_valid_reg ? h_wgt_reg   : (d_valid_reg ? bus.wgt_rdata : '0);
  assign bus.out_first   = h_valid_reg ? h_first_reg : (d_valid_reg & first_d_reg);
  assign bus.out_last    = h_valid_reg ? h_last_reg  : (d_valid_reg & last_d_reg);
  assign bus.out_wb_addr = h_valid_reg ? h_wb_reg    : (d_valid_reg ? wb_d_reg      : '0);
endmodule
